// File: rtl/shift_sequencer.sv
// Sequences one load plus N shifts on an external 16-bit shift register and returns the result.
// Optional SHIFT_SEQ_ABORT_EN adds an abort input and an aborted pulse output.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | ready; waiting for start
// S_LOAD    | sr_load_enable high; register loads at the closing edge
// S_SHIFT   | sr_shift_enable high; one shift per cycle, cnt counts down
// S_CAPTURE | enables low; result captured at the closing edge, done next
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             s_rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] shift_count,
    input  logic             dir,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] sr_parallel_in,
    output logic             sr_load_enable,
    output logic             sr_shift_enable,
    output logic             sr_left_right,
    input  logic [WIDTH-1:0] sr_parallel_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_SHIFT   = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] count_clamped;
    logic             accept;
    logic             cnt_last;
    logic             abort_hit;

    logic             done_d;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] sr_parallel_in_d;
    logic             sr_load_enable_d;
    logic             sr_shift_enable_d;
    logic             sr_left_right_d;

`ifdef SHIFT_SEQ_ABORT_EN
    assign abort_hit = abort && (state != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign count_clamped = (shift_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shift_count;
    assign accept        = (state == S_IDLE) && start;
    assign cnt_last      = (cnt == CNT_W'(1));
    assign ready         = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            state           <= S_IDLE;
            cnt             <= '0;
            done            <= 1'b0;
            result          <= '0;
            sr_parallel_in  <= '0;
            sr_load_enable  <= 1'b0;
            sr_shift_enable <= 1'b0;
            sr_left_right   <= 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
            aborted         <= 1'b0;
`endif
        end else begin
            state           <= next_state;
            cnt             <= cnt_d;
            done            <= done_d;
            result          <= result_d;
            sr_parallel_in  <= sr_parallel_in_d;
            sr_load_enable  <= sr_load_enable_d;
            sr_shift_enable <= sr_shift_enable_d;
            sr_left_right   <= sr_left_right_d;
`ifdef SHIFT_SEQ_ABORT_EN
            aborted         <= abort_hit;
`endif
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                next_state = (cnt != '0) ? S_SHIFT : S_CAPTURE;
            end
            S_SHIFT: begin
                if (cnt_last) begin
                    next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        if (abort_hit) begin
            next_state = S_IDLE;
        end
    end

    // Registered outputs are decoded from the state being entered, so they line up with it.
    always_comb begin
        cnt_d             = cnt;
        result_d          = result;
        sr_parallel_in_d  = sr_parallel_in;
        sr_left_right_d   = sr_left_right;
        sr_load_enable_d  = (next_state == S_LOAD);
        sr_shift_enable_d = (next_state == S_SHIFT);
        done_d            = (state == S_CAPTURE) && !abort_hit;

        if (accept) begin
            cnt_d            = count_clamped;
            sr_parallel_in_d = data_in;
            sr_left_right_d  = dir;
        end

        if (state == S_SHIFT) begin
            cnt_d = cnt - CNT_W'(1);
        end

        if (abort_hit) begin
            cnt_d = '0;
        end

        if (done_d) begin
            result_d = sr_parallel_out;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer driving a behavioural 16-bit shift register.
// Build with SHIFT_SEQ_ABORT_EN defined to exercise the abort path as well.
module tb_shift_sequencer;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             s_rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [CNT_W-1:0] shift_count = '0;
    logic             dir = 1'b0;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] sr_parallel_in;
    logic             sr_load_enable;
    logic             sr_shift_enable;
    logic             sr_left_right;
    logic [WIDTH-1:0] sr_q = '0;
`ifdef SHIFT_SEQ_ABORT_EN
    logic             abort = 1'b0;
    logic             aborted;
`endif

    int checks = 0;
    int errors = 0;
    int load_cycles = 0;
    int shift_cycles = 0;
    int overlap_cycles = 0;
    int done_cycles = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .s_rst_n         (s_rst_n),
        .start           (start),
        .data_in         (data_in),
        .shift_count     (shift_count),
        .dir             (dir),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort           (abort),
        .aborted         (aborted),
`endif
        .ready           (ready),
        .done            (done),
        .result          (result),
        .sr_parallel_in  (sr_parallel_in),
        .sr_load_enable  (sr_load_enable),
        .sr_shift_enable (sr_shift_enable),
        .sr_left_right   (sr_left_right),
        .sr_parallel_out (sr_q)
    );

    // shiftreg16 stand-in: load wins over shift, zero fill, left_right=1 shifts toward MSB
    always @(posedge clk) begin
        if (sr_load_enable)
            sr_q <= sr_parallel_in;
        else if (sr_shift_enable)
            sr_q <= sr_left_right ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
    end

    always @(posedge clk) begin
        if (sr_load_enable) load_cycles++;
        if (sr_shift_enable) shift_cycles++;
        if (sr_load_enable && sr_shift_enable) overlap_cycles++;
        if (done) done_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is raised immediately, so a call right after done tests back-to-back accept.
    task automatic run(input string tag, input logic [15:0] d, input logic [4:0] c, input logic dr,
                       input logic [15:0] exp_res, input int exp_shifts);
        int l0, s0, lat;
        bit got;
        start = 1'b1; data_in = d; shift_count = c; dir = dr;
        l0 = load_cycles; s0 = shift_cycles;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; data_in = 16'hDEAD; shift_count = 5'd3; dir = ~dr;
        got = 1'b0; lat = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                lat = i;
            end
        end
        chk({tag, "_latency"}, lat, exp_shifts + 2);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_loads"}, load_cycles - l0, 1);
        chk({tag, "_shifts"}, shift_cycles - s0, exp_shifts);
        chk({tag, "_ready"}, ready, 1'b1);
    endtask

    initial begin
        int l0, s0, d0;
        logic [15:0] last_result;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 16'h0000);
        chk("rst_sr_in", sr_parallel_in, 16'h0000);
        chk("rst_enables", {sr_load_enable, sr_shift_enable, sr_left_right}, 3'b000);
        chk("rst_ready", ready, 1'b1);
        s_rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", ready, 1'b1);

        run("left4",   16'h00F0, 5'd4,  1'b1, 16'h0F00, 4);
        run("right4",  16'h00F0, 5'd4,  1'b0, 16'h000F, 4);
        run("zero",    16'hA5A5, 5'd0,  1'b1, 16'hA5A5, 0);
        run("clamp20", 16'hFFFF, 5'd20, 1'b1, 16'h0000, 16);
        run("right1",  16'h8001, 5'd1,  1'b0, 16'h4000, 1);
        run("left15",  16'h0001, 5'd15, 1'b1, 16'h8000, 15);
        run("right16", 16'h1234, 5'd16, 1'b0, 16'h0000, 16);

        // Held result must survive idle cycles.
        repeat (3) @(negedge clk);
        chk("hold_result", result, 16'h0000);

        // Reset mid-shift: ignored start while busy, then reset in shift cycle 5.
        l0 = load_cycles; s0 = shift_cycles; d0 = done_cycles;
        start = 1'b1; data_in = 16'h1234; shift_count = 5'd8; dir = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        start = 1'b1; data_in = 16'hFFFF; shift_count = 5'd1; dir = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("busy_ready", ready, 1'b0);
        s_rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_result", result, 16'h0000);
        chk("mid_rst_sr_in", sr_parallel_in, 16'h0000);
        chk("mid_rst_enables", {sr_load_enable, sr_shift_enable, sr_left_right}, 3'b000);
        chk("mid_rst_ready", ready, 1'b1);
        chk("mid_rst_loads", load_cycles - l0, 1);
        chk("mid_rst_shifts", shift_cycles - s0, 5);
        s_rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_rst_no_done", done_cycles - d0, 0);
        run("fresh", 16'h00F0, 5'd2, 1'b0, 16'h003C, 2);
        last_result = 16'h003C;

`ifdef SHIFT_SEQ_ABORT_EN
        d0 = done_cycles;
        @(negedge clk);
        chk("idle_abort_ready", ready, 1'b1);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_ignored", aborted, 1'b0);
        start = 1'b1; data_in = 16'h1234; shift_count = 5'd6; dir = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_pulse", aborted, 1'b1);
        chk("abort_enables", {sr_load_enable, sr_shift_enable}, 2'b00);
        chk("abort_ready", ready, 1'b1);
        chk("abort_result", result, last_result);
        @(negedge clk);
        chk("abort_pulse_end", aborted, 1'b0);
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_cycles - d0, 0);
        chk("abort_result_kept", result, last_result);
        run("after_abort", 16'h0001, 5'd1, 1'b1, 16'h0002, 1);
`endif

        chk("enable_overlap", overlap_cycles, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
